pipe_mux_skid: RTL

PIPE_MUX_SKID -- requirements
Module: pipe_mux_skid

---
 rtl/pipe_mux_skid.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_mux_skid.sv
// -----------------------------------------------------------------------------
// pipe_mux_skid
//   Selects one of NUM_IN input channels and registers it into a two-entry
//   pipeline stage (main register + skid register). in_ready comes straight
//   from a flop, so the upstream ready path is fully registered.
//
//   Parameters
//     WIDTH   data bits per channel
//     NUM_IN  number of input channels (2..16)
//     SEL_W   derived select width, max(1, ceil(log2(NUM_IN)))
//
//   Ports
//     clk        rising-edge clock
//     reset_n    synchronous active-low reset
//     in_bus     flattened channels, channel k at [k*WIDTH +: WIDTH]
//     sel        channel select, qualified by in_valid
//     in_valid   upstream beat present
//     in_ready   block can accept a beat (registered)
//     flush      synchronous flush, empties the stage
//     out_data   registered output word
//     out_valid  out_data holds a valid beat
//     out_ready  downstream accepts the beat
//     sel_err    sticky out-of-range select flag
//
//   Optional feature
//     PIPE_MUX_SKID_SEL_CHECK_EN : when defined, sel_err sets on any accept
//     with sel >= NUM_IN and stays set until reset. When undefined, sel_err
//     is tied low. An out-of-range select always captures the zero word.
// -----------------------------------------------------------------------------
module pipe_mux_skid #(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_n_s;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] main_n_s;
  logic [WIDTH-1:0] skid_r;
  logic [WIDTH-1:0] skid_n_s;
  logic             out_valid_r;
  logic             in_ready_r;
  logic             accept_s;
  logic             consume_s;
  logic [WIDTH-1:0] word_s;

  // Channel mux; a select with no matching channel yields the zero word.
  function automatic logic [WIDTH-1:0] pick_channel(
    input logic [NUM_IN*WIDTH-1:0] bus,
    input logic [SEL_W-1:0]        s
  );
    logic [WIDTH-1:0] w;
    w = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (s == SEL_W'(k)) begin
        w = bus[k*WIDTH +: WIDTH];
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  assign accept_s  = in_valid && in_ready_r;
  assign consume_s = out_valid_r && out_ready;
  assign word_s    = pick_channel(in_bus, sel);

  // Next-state and next-register contents; flush overrides all traffic.
  always_comb begin
    state_n_s = state_r;
    main_n_s  = main_r;
    skid_n_s  = skid_r;
    if (flush) begin
      state_n_s = EMPTY;
      main_n_s  = '0;
      skid_n_s  = '0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            main_n_s  = word_s;
            state_n_s = ONE;
          end else begin
            state_n_s = EMPTY;
          end
        end
        ONE: begin
          if (accept_s && consume_s) begin
            main_n_s  = word_s;
            state_n_s = ONE;
          end else if (accept_s) begin
            // Downstream stalled: park the new beat behind main.
            skid_n_s  = word_s;
            state_n_s = FULL;
          end else if (consume_s) begin
            // main keeps its value so out_data holds while idle.
            state_n_s = EMPTY;
          end else begin
            state_n_s = ONE;
          end
        end
        FULL: begin
          if (consume_s) begin
            main_n_s  = skid_r;
            state_n_s = ONE;
          end else begin
            state_n_s = FULL;
          end
        end
        default: begin
          state_n_s = EMPTY;
          main_n_s  = '0;
          skid_n_s  = '0;
        end
      endcase
    end
  end

  // State, data and handshake registers; ready/valid follow the next state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= EMPTY;
      main_r      <= '0;
      skid_r      <= '0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_n_s;
      main_r      <= main_n_s;
      skid_r      <= skid_n_s;
      out_valid_r <= (state_n_s != EMPTY);
      in_ready_r  <= (state_n_s != FULL);
    end
  end

  assign out_data  = main_r;
  assign out_valid = out_valid_r;
  assign in_ready  = in_ready_r;

`ifdef PIPE_MUX_SKID_SEL_CHECK_EN
  localparam logic [31:0] NUM_IN_U = 32'(NUM_IN);

  logic sel_err_r;
  logic sel_oob_s;

  assign sel_oob_s = ({{(32-SEL_W){1'b0}}, sel} >= NUM_IN_U);

  // Sticky flag: set by any out-of-range accept, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel_err_r <= 1'b0;
    end else if (accept_s && sel_oob_s) begin
      sel_err_r <= 1'b1;
    end else begin
      sel_err_r <= sel_err_r;
    end
  end

  assign sel_err = sel_err_r;
`else
  assign sel_err = 1'b0;
`endif

endmodule
